// File: rtl/rr_onehot_arbiter.sv
// Round-robin arbiter with a registered one-hot grant, hold-until-ack semantics
// and a forced release (with a one-cycle timeout_err pulse) after MAX_HOLD cycles.
`timescale 1ns/1ps
module rr_onehot_arbiter #(
  parameter int N        = 5,
  parameter int MAX_HOLD = 15
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic [N-1:0]         req,
  input  logic                 ack,
  output logic [N-1:0]         gnt,
  output logic                 gnt_valid,
  output logic [$clog2(N)-1:0] gnt_idx,
  output logic                 timeout_err
);
  localparam int IW = $clog2(N);
  localparam int HW = $clog2(MAX_HOLD);

  typedef enum logic {IDLE = 1'b0, GRANT = 1'b1} state_t;

  state_t         state_q, state_d;
  logic [IW-1:0]  ptr_q, ptr_d;
  logic [HW-1:0]  hold_cnt_q, hold_cnt_d;
  logic [N-1:0]   gnt_q, gnt_d;
  logic           gnt_valid_q, gnt_valid_d;
  logic [IW-1:0]  gnt_idx_q, gnt_idx_d;
  logic           timeout_err_q, timeout_err_d;

  logic [N-1:0]   req_clean;
  logic [IW-1:0]  next_ptr, start, win_idx;
  logic           win_found, forced, release_now;

  // Only a definite 1 counts as a request, so X/Z request bits never reach gnt.
  always_comb begin
    for (int i = 0; i < N; i++) begin
      req_clean[i] = (req[i] === 1'b1);
    end
  end

  assign next_ptr = (gnt_idx_q == IW'(N - 1)) ? '0 : gnt_idx_q + 1'b1;
  assign forced      = (state_q == GRANT) && !ack && (hold_cnt_q == HW'(MAX_HOLD - 1));
  assign release_now = (state_q == GRANT) && (ack || forced);
  // A release searches from the slot after the current winner, same edge.
  assign start       = (state_q == GRANT) ? next_ptr : ptr_q;

  // Scan from the far end so the lowest rotated offset is written last and wins.
  always_comb begin
    int j;
    j         = 0;
    win_found = 1'b0;
    win_idx   = '0;
    for (int k = N - 1; k >= 0; k--) begin
      j = int'(start) + k;
      if (j >= N) j = j - N;
      if (req_clean[j]) begin
        win_found = 1'b1;
        win_idx   = IW'(j);
      end
    end
  end

  always_comb begin
    state_d       = state_q;
    ptr_d         = ptr_q;
    hold_cnt_d    = hold_cnt_q;
    gnt_d         = gnt_q;
    gnt_valid_d   = gnt_valid_q;
    gnt_idx_d     = gnt_idx_q;
    timeout_err_d = forced;
    if (state_q == IDLE || release_now) begin
      if (release_now) ptr_d = next_ptr;
      hold_cnt_d = '0;
      if (win_found) begin
        state_d     = GRANT;
        gnt_d       = {{(N-1){1'b0}}, 1'b1} << win_idx;
        gnt_valid_d = 1'b1;
        gnt_idx_d   = win_idx;
      end else begin
        state_d     = IDLE;
        gnt_d       = '0;
        gnt_valid_d = 1'b0;
        gnt_idx_d   = '0;
      end
    end else begin
      hold_cnt_d = hold_cnt_q + 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q       <= IDLE;
      ptr_q         <= '0;
      hold_cnt_q    <= '0;
      gnt_q         <= '0;
      gnt_valid_q   <= 1'b0;
      gnt_idx_q     <= '0;
      timeout_err_q <= 1'b0;
    end else begin
      state_q       <= state_d;
      ptr_q         <= ptr_d;
      hold_cnt_q    <= hold_cnt_d;
      gnt_q         <= gnt_d;
      gnt_valid_q   <= gnt_valid_d;
      gnt_idx_q     <= gnt_idx_d;
      timeout_err_q <= timeout_err_d;
    end
  end

  assign gnt         = gnt_q;
  assign gnt_valid   = gnt_valid_q;
  assign gnt_idx     = gnt_idx_q;
  assign timeout_err = timeout_err_q;
endmodule

// File: tb/tb_rr_onehot_arbiter.sv
// Scoreboard bench for rr_onehot_arbiter: expectations are queued with the stimulus
// and popped once the registered outputs settle after each edge.
`timescale 1ns/1ps
module tb_rr_onehot_arbiter;
  localparam int N        = 5;
  localparam int MAX_HOLD = 15;

  logic         clk   = 1'b0;
  logic         rst_n = 1'b0;
  logic         ack   = 1'b0;
  logic [N-1:0] req   = '0;
  logic [N-1:0] gnt;
  logic         gnt_valid;
  logic [2:0]   gnt_idx;
  logic         timeout_err;

  int n_checks = 0;
  int n_fail   = 0;

  typedef struct {
    logic [N-1:0] gnt;
    logic         valid;
    logic [2:0]   idx;
    logic         terr;
    string        name;
  } exp_t;
  exp_t exp_q[$];

  always #5 clk = ~clk;

  rr_onehot_arbiter #(.N(N), .MAX_HOLD(MAX_HOLD)) dut (
    .clk(clk), .rst_n(rst_n), .req(req), .ack(ack),
    .gnt(gnt), .gnt_valid(gnt_valid), .gnt_idx(gnt_idx), .timeout_err(timeout_err)
  );

  a_onehot: assert property (@(posedge clk) disable iff (!rst_n)
      gnt_valid |-> ($onehot(gnt) && gnt[gnt_idx]))
    else begin
      n_fail++;
      $display("FAIL a_onehot: gnt=%b gnt_idx=%0d, required one-hot with gnt[gnt_idx]=1", gnt, gnt_idx);
    end

  a_zero: assert property (@(posedge clk) disable iff (!rst_n) !gnt_valid |-> (gnt == '0))
    else begin
      n_fail++;
      $display("FAIL a_zero: gnt=%b with gnt_valid=0, required 00000", gnt);
    end

  function automatic void expect_out(logic [N-1:0] g, logic v, logic [2:0] i, logic t, string nm);
    exp_t e;
    e.gnt = g; e.valid = v; e.idx = i; e.terr = t; e.name = nm;
    exp_q.push_back(e);
  endfunction

  task automatic drive(input logic [N-1:0] r, input logic a);
    @(negedge clk);
    req = r;
    ack = a;
  endtask

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset;
    @(negedge clk);
    rst_n = 1'b0; req = '0; ack = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  task automatic test_reset;
    exp_t e;
    rst_n = 1'b0; req = '0; ack = 1'b0;
    #3;
    expect_out('0, 1'b0, 3'd0, 1'b0, "reset_held");
    e = exp_q.pop_front(); n_checks++;
    if ({gnt, gnt_valid, gnt_idx, timeout_err} !== {e.gnt, e.valid, e.idx, e.terr}) begin
      n_fail++;
      $display("FAIL %s: gnt=%b valid=%b idx=%0d terr=%b, expected gnt=%b valid=%b idx=%0d terr=%b",
               e.name, gnt, gnt_valid, gnt_idx, timeout_err, e.gnt, e.valid, e.idx, e.terr);
    end else $display("pass %s: gnt=%b valid=%b idx=%0d terr=%b", e.name, gnt, gnt_valid, gnt_idx, timeout_err);
    @(negedge clk);
    rst_n = 1'b1;
    // ack while idle must be ignored
    for (int c = 0; c < 3; c++) begin
      drive('0, 1'b1);
      expect_out('0, 1'b0, 3'd0, 1'b0, $sformatf("idle_after_reset_%0d", c));
      tick();
      e = exp_q.pop_front(); n_checks++;
      if ({gnt, gnt_valid, gnt_idx, timeout_err} !== {e.gnt, e.valid, e.idx, e.terr}) begin
        n_fail++;
        $display("FAIL %s: gnt=%b valid=%b idx=%0d terr=%b, expected gnt=%b valid=%b idx=%0d terr=%b",
                 e.name, gnt, gnt_valid, gnt_idx, timeout_err, e.gnt, e.valid, e.idx, e.terr);
      end else $display("pass %s: gnt=%b valid=%b idx=%0d terr=%b", e.name, gnt, gnt_valid, gnt_idx, timeout_err);
    end
  endtask

  task automatic test_priority;
    exp_t e;
    logic [N-1:0] r_t [4] = '{5'b10100, 5'b10100, 5'b10100, 5'b00000};
    logic         a_t [4] = '{1'b0, 1'b1, 1'b1, 1'b1};
    logic [N-1:0] g_t [4] = '{5'b00100, 5'b10000, 5'b00100, 5'b00000};
    logic [2:0]   i_t [4] = '{3'd2, 3'd4, 3'd2, 3'd0};
    logic         v_t [4] = '{1'b1, 1'b1, 1'b1, 1'b0};
    for (int s = 0; s < 4; s++) begin
      drive(r_t[s], a_t[s]);
      expect_out(g_t[s], v_t[s], i_t[s], 1'b0, $sformatf("priority_%0d", s));
      tick();
      e = exp_q.pop_front(); n_checks++;
      if ({gnt, gnt_valid, gnt_idx, timeout_err} !== {e.gnt, e.valid, e.idx, e.terr}) begin
        n_fail++;
        $display("FAIL %s: gnt=%b valid=%b idx=%0d terr=%b, expected gnt=%b valid=%b idx=%0d terr=%b",
                 e.name, gnt, gnt_valid, gnt_idx, timeout_err, e.gnt, e.valid, e.idx, e.terr);
      end else $display("pass %s: gnt=%b valid=%b idx=%0d terr=%b", e.name, gnt, gnt_valid, gnt_idx, timeout_err);
    end
  endtask

  task automatic test_back_to_back;
    exp_t e;
    logic         a_t [7] = '{1'b0, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1};
    logic [N-1:0] g_t [7] = '{5'b00001, 5'b00010, 5'b00100, 5'b01000, 5'b10000, 5'b00001, 5'b00000};
    logic [2:0]   i_t [7] = '{3'd0, 3'd1, 3'd2, 3'd3, 3'd4, 3'd0, 3'd0};
    do_reset();
    for (int s = 0; s < 7; s++) begin
      drive((s < 6) ? 5'b11111 : 5'b00000, a_t[s]);
      expect_out(g_t[s], (s < 6), i_t[s], 1'b0, $sformatf("back_to_back_%0d", s));
      tick();
      e = exp_q.pop_front(); n_checks++;
      if ({gnt, gnt_valid, gnt_idx, timeout_err} !== {e.gnt, e.valid, e.idx, e.terr}) begin
        n_fail++;
        $display("FAIL %s: gnt=%b valid=%b idx=%0d terr=%b, expected gnt=%b valid=%b idx=%0d terr=%b",
                 e.name, gnt, gnt_valid, gnt_idx, timeout_err, e.gnt, e.valid, e.idx, e.terr);
      end else $display("pass %s: gnt=%b valid=%b idx=%0d terr=%b", e.name, gnt, gnt_valid, gnt_idx, timeout_err);
    end
  endtask

  task automatic test_timeout;
    exp_t e;
    do_reset();
    // Grant taken on edge 0, forced release on edges 15 and 30 (hold restarts at re-grant).
    for (int c = 0; c <= 31; c++) begin
      if (c <= 30) begin
        drive(5'b00010, 1'b0);
        expect_out(5'b00010, 1'b1, 3'd1, (c == 15 || c == 30), $sformatf("timeout_edge_%0d", c));
      end else begin
        drive(5'b00000, 1'b1);
        expect_out(5'b00000, 1'b0, 3'd0, 1'b0, "timeout_release");
      end
      tick();
      e = exp_q.pop_front(); n_checks++;
      if ({gnt, gnt_valid, gnt_idx, timeout_err} !== {e.gnt, e.valid, e.idx, e.terr}) begin
        n_fail++;
        $display("FAIL %s: gnt=%b valid=%b idx=%0d terr=%b, expected gnt=%b valid=%b idx=%0d terr=%b",
                 e.name, gnt, gnt_valid, gnt_idx, timeout_err, e.gnt, e.valid, e.idx, e.terr);
      end else $display("pass %s: gnt=%b valid=%b idx=%0d terr=%b", e.name, gnt, gnt_valid, gnt_idx, timeout_err);
    end
  endtask

  task automatic test_reset_mid_grant;
    exp_t e;
    do_reset();
    for (int s = 0; s < 4; s++) begin
      if (s == 0) begin
        drive(5'b01000, 1'b0);
        expect_out(5'b01000, 1'b1, 3'd3, 1'b0, "mid_grant_taken");
        tick();
      end else if (s == 1) begin
        drive(5'b00000, 1'b0);
        expect_out(5'b01000, 1'b1, 3'd3, 1'b0, "mid_grant_held");
        tick();
      end else if (s == 2) begin
        #2;
        rst_n = 1'b0;
        #1;
        expect_out(5'b00000, 1'b0, 3'd0, 1'b0, "mid_grant_async_reset");
      end else begin
        @(negedge clk);
        req = 5'b01001; ack = 1'b0; rst_n = 1'b1;
        expect_out(5'b00001, 1'b1, 3'd0, 1'b0, "first_grant_after_reset");
        tick();
      end
      e = exp_q.pop_front(); n_checks++;
      if ({gnt, gnt_valid, gnt_idx, timeout_err} !== {e.gnt, e.valid, e.idx, e.terr}) begin
        n_fail++;
        $display("FAIL %s: gnt=%b valid=%b idx=%0d terr=%b, expected gnt=%b valid=%b idx=%0d terr=%b",
                 e.name, gnt, gnt_valid, gnt_idx, timeout_err, e.gnt, e.valid, e.idx, e.terr);
      end else $display("pass %s: gnt=%b valid=%b idx=%0d terr=%b", e.name, gnt, gnt_valid, gnt_idx, timeout_err);
    end
  endtask

  task automatic test_xreq;
    exp_t e;
    logic [N-1:0] xr;
    xr = 5'bx0100;
    do_reset();
    for (int s = 0; s < 2; s++) begin
      if (s == 0) begin
        drive(xr, 1'b0);
        expect_out(5'b00100, 1'b1, 3'd2, 1'b0, "xreq_grant");
      end else begin
        drive(5'b00000, 1'b1);
        expect_out(5'b00000, 1'b0, 3'd0, 1'b0, "xreq_release");
      end
      tick();
      e = exp_q.pop_front(); n_checks++;
      if ({gnt, gnt_valid, gnt_idx, timeout_err} !== {e.gnt, e.valid, e.idx, e.terr}) begin
        n_fail++;
        $display("FAIL %s: gnt=%b valid=%b idx=%0d terr=%b, expected gnt=%b valid=%b idx=%0d terr=%b",
                 e.name, gnt, gnt_valid, gnt_idx, timeout_err, e.gnt, e.valid, e.idx, e.terr);
      end else $display("pass %s: gnt=%b valid=%b idx=%0d terr=%b", e.name, gnt, gnt_valid, gnt_idx, timeout_err);
    end
  endtask

  initial begin
    test_reset();
    test_priority();
    test_back_to_back();
    test_timeout();
    test_reset_mid_grant();
    test_xreq();
    n_checks++;
    if (exp_q.size() != 0) begin
      n_fail++;
      $display("FAIL scoreboard_drain: %0d entries left, expected 0", exp_q.size());
    end
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached, expected tests to complete");
    $fatal(1, "watchdog");
  end
endmodule
